// File: rtl/ntt_addr_gen.sv
// NTT address generator: maps FSM loop indices (p, k, i) to conflict-free bank
// addresses, lane->bank crossbar selects and twiddle indices, plus a write-back delay pipe.

module ntt_bank_map (
  input  logic [9:0] a,
  output logic [1:0] bank,
  output logic [7:0] off
);
  // XOR-folded bank select: flipping any single adjacent bit pair visits all 4 banks
  assign bank = {a[1] ^ a[3] ^ a[5] ^ a[7] ^ a[9], a[0] ^ a[2] ^ a[4] ^ a[6] ^ a[8]};
  assign off  = a[9:2];
endmodule

module ntt_addr_gen #(
  parameter int WB_LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  p,
  input  logic [7:0]  k,
  input  logic [7:0]  i,
  input  logic        ren,
  input  logic        sel,
  output logic        rd_valid,
  output logic [31:0] rd_addr,
  output logic [7:0]  rd_lane_bank,
  output logic [9:0]  tw_idx0,
  output logic [9:0]  tw_idx1,
  output logic        tw_sel,
  output logic        wr_valid,
  output logic [31:0] wr_addr,
  output logic [7:0]  wr_lane_bank
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef struct packed {
    logic [NUM_LANES-1:0][VEC_W-1:0] addr;
    logic [NUM_LANES-1:0][1:0]       lane_bank;
  } wb_t;

  logic [9:0]                      j_dist, j_half, base;
  logic [NUM_LANES-1:0][9:0]       la;
  logic [NUM_LANES-1:0][1:0]       lb;
  logic [NUM_LANES-1:0][VEC_W-1:0] lo;
  logic [NUM_LANES-1:0][VEC_W-1:0] addr_n;
  logic [9:0]                      tw0_n, tw1_n;
  logic                            legal;

  always_comb begin
    j_dist = 10'd1 << p;
    j_half = j_dist >> 1;
    base   = ({2'b00, k} << (p + 4'd1)) + {2'b00, i};
    if (p == 4'd0) begin
      for (int j = 0; j < NUM_LANES; j++) la[j] = {k, 2'(j)};
    end else begin
      la[0] = base;
      la[1] = base + j_dist;
      la[2] = base + j_half;
      la[3] = base + j_half + j_dist;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ntt_bank_map u_map (.a(la[g]), .bank(lb[g]), .off(lo[g]));
  end

  // Lanes hit distinct banks, so scattering offsets by bank never collides
  always_comb begin
    addr_n = '0;
    for (int j = 0; j < NUM_LANES; j++) addr_n[lb[j]] = lo[j];
  end

  always_comb begin
    if (p == 4'd0) begin
      tw0_n = 10'd512 + {1'b0, k, 1'b0};
      tw1_n = tw0_n + 10'd1;
    end else begin
      tw0_n = (10'd512 >> p) + {2'b00, k};
      tw1_n = tw0_n;
    end
  end

  assign legal = (p <= 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid     <= 1'b0;
      rd_addr      <= '0;
      rd_lane_bank <= '0;
      tw_idx0      <= '0;
      tw_idx1      <= '0;
      tw_sel       <= 1'b0;
    end else begin
      rd_valid <= ren && legal;
      if (ren) begin
        rd_addr      <= addr_n;
        rd_lane_bank <= lb;
        tw_idx0      <= tw0_n;
        tw_idx1      <= tw1_n;
        tw_sel       <= sel;
      end
    end
  end

  // Write-back pipe free-runs so it drains after issue stops
  logic [WB_LAT:1] vld_pipe;
  wb_t             dat_pipe [1:WB_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int s = 1; s <= WB_LAT; s++) dat_pipe[s] <= '0;
    end else begin
      vld_pipe[1] <= rd_valid;
      dat_pipe[1] <= {rd_addr, rd_lane_bank};
      for (int s = 2; s <= WB_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign wr_valid     = vld_pipe[WB_LAT];
  assign wr_addr      = dat_pipe[WB_LAT].addr;
  assign wr_lane_bank = dat_pipe[WB_LAT].lane_bank;
endmodule
